ecfg_regs: RTL and testbench

ECFG_REGS -- requirements
Module: ecfg_regs

---
 rtl/ecfg_pkg.sv | 41 ++++
 rtl/ecfg_if.sv | 13 +
 rtl/ecfg_pulse_gen.sv | 29 ++
 rtl/ecfg_regs.sv | 125 ++++++++++++
 tb/tb_ecfg_regs.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ecfg_pkg.sv
// Shared constants and helpers for the ecfg register block.
package ecfg_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned WE_W      = 4;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned STATUS_W  = 8;
  localparam int unsigned RST_CNT_W = 8;

  // Byte offsets of the registers inside the 32-byte window
  localparam logic [ADDR_W-1:0] OFS_RESET   = 16'h0000;
  localparam logic [ADDR_W-1:0] OFS_CFG     = 16'h0004;
  localparam logic [ADDR_W-1:0] OFS_STATUS  = 16'h0008;
  localparam logic [ADDR_W-1:0] OFS_VERSION = 16'h000C;
  localparam logic [ADDR_W-1:0] OFS_TIMER   = 16'h0010;
  localparam logic [ADDR_W-1:0] OFS_SCRATCH = 16'h0014;

  // Word selects derived from the offsets (address bits [4:2])
  localparam logic [SEL_W-1:0] SEL_RESET   = OFS_RESET[4:2];
  localparam logic [SEL_W-1:0] SEL_CFG     = OFS_CFG[4:2];
  localparam logic [SEL_W-1:0] SEL_STATUS  = OFS_STATUS[4:2];
  localparam logic [SEL_W-1:0] SEL_VERSION = OFS_VERSION[4:2];
  localparam logic [SEL_W-1:0] SEL_TIMER   = OFS_TIMER[4:2];
  localparam logic [SEL_W-1:0] SEL_SCRATCH = OFS_SCRATCH[4:2];

  // Replace only the byte lanes whose write enable is set
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] cur,
    input logic [DATA_W-1:0] din,
    input logic [WE_W-1:0]   we
  );
    logic [DATA_W-1:0] res;
    res = cur;
    for (int i = 0; i < WE_W; i++) begin
      if (we[i]) res[8*i +: 8] = din[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ecfg_if.sv
// Memory-style access port between the AXI-lite bridge and ecfg_regs.
interface ecfg_if;
  import ecfg_pkg::*;

  logic              mi_en;
  logic [WE_W-1:0]   mi_we;
  logic [ADDR_W-1:0] mi_addr;
  logic [DATA_W-1:0] mi_din;
  logic [DATA_W-1:0] mi_rd_data;

  modport master (output mi_en, mi_we, mi_addr, mi_din, input mi_rd_data);
  modport slave  (input mi_en, mi_we, mi_addr, mi_din, output mi_rd_data);
endinterface

// File: rtl/ecfg_pulse_gen.sv
// Fixed-length software reset pulse; re-triggers while busy are ignored.
module ecfg_pulse_gen
  import ecfg_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy
);

  logic [RST_CNT_W-1:0] count;

  // Load on an idle trigger, then count down; busy is high exactly while count != 0
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      busy  <= 1'b0;
    end else if (load && !busy) begin
      count <= RST_CNT_W'(RST_CYCLES);
      busy  <= 1'b1;
    end else if (busy) begin
      count <= count - RST_CNT_W'(1);
      busy  <= (count > RST_CNT_W'(1));
    end
  end

endmodule

// File: rtl/ecfg_regs.sv
// ecfg configuration register block.
// Optional TIMER register and timer_expired pulse are built only when
// ECFG_TIMER_EN is defined; otherwise 0x10 reads 0 and timer_expired is 0.
module ecfg_regs
  import ecfg_pkg::*;
#(
  parameter int unsigned       RST_CYCLES = 16,
  parameter logic [DATA_W-1:0] VERSION    = 32'h0000_0100
) (
  input  logic                clk,
  input  logic                reset,
  ecfg_if.slave               mi,
  input  logic [STATUS_W-1:0] status_in,
  output logic                soft_reset,
  output logic [DATA_W-1:0]   ecfg_cfg,
  output logic                timer_expired
);

  logic                hit;
  logic                wr_hit;
  logic                rd_hit;
  logic [SEL_W-1:0]    sel;
  logic                wr_cfg;
  logic                wr_scratch;
  logic                wr_timer;
  logic                rst_trig;
  logic [STATUS_W-1:0] status_clr;
  logic [STATUS_W-1:0] status_q;
  logic [DATA_W-1:0]   scratch_q;
  logic [DATA_W-1:0]   timer_q;
  logic [DATA_W-1:0]   rd_val;
  logic                unused_addr;

  // Byte-offset bits inside a word carry no meaning for this block
  assign unused_addr = ^mi.mi_addr[1:0];

  // Address decode: only the low 32-byte window responds
  always_comb begin
    sel        = mi.mi_addr[4:2];
    hit        = mi.mi_en && (mi.mi_addr[ADDR_W-1:5] == '0);
    wr_hit     = hit && (mi.mi_we != '0);
    rd_hit     = hit && (mi.mi_we == '0);
    wr_cfg     = wr_hit && (sel == SEL_CFG);
    wr_scratch = wr_hit && (sel == SEL_SCRATCH);
    wr_timer   = wr_hit && (sel == SEL_TIMER);
    rst_trig   = wr_hit && (sel == SEL_RESET) && mi.mi_we[0] && mi.mi_din[0];
    status_clr = (wr_hit && (sel == SEL_STATUS) && mi.mi_we[0])
                 ? mi.mi_din[STATUS_W-1:0] : '0;
  end

  ecfg_pulse_gen #(
    .RST_CYCLES (RST_CYCLES)
  ) u_pulse (
    .clk   (clk),
    .reset (reset),
    .load  (rst_trig),
    .busy  (soft_reset)
  );

  // CFG and SCRATCH: byte-lane writable storage
  always_ff @(posedge clk) begin
    if (reset) begin
      ecfg_cfg  <= '0;
      scratch_q <= '0;
    end else begin
      if (wr_cfg)     ecfg_cfg  <= byte_merge(ecfg_cfg, mi.mi_din, mi.mi_we);
      if (wr_scratch) scratch_q <= byte_merge(scratch_q, mi.mi_din, mi.mi_we);
    end
  end

  // STATUS: sticky set from status_in, W1C from software; set wins
  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= '0;
    end else begin
      status_q <= (status_q & ~status_clr) | status_in;
    end
  end

`ifdef ECFG_TIMER_EN
  // TIMER: saturating down-counter; a write overrides the decrement
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q       <= '0;
      timer_expired <= 1'b0;
    end else begin
      timer_expired <= !wr_timer && (timer_q == DATA_W'(1));
      if (wr_timer) begin
        timer_q <= byte_merge(timer_q, mi.mi_din, mi.mi_we);
      end else if (timer_q != '0) begin
        timer_q <= timer_q - DATA_W'(1);
      end
    end
  end
`else
  assign timer_q       = '0;
  assign timer_expired = 1'b0;
  logic unused_timer;
  assign unused_timer = wr_timer;
`endif

  // Read mux; unmapped words inside the window read as 0
  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_RESET:   rd_val = {{(DATA_W-1){1'b0}}, soft_reset};
      SEL_CFG:     rd_val = ecfg_cfg;
      SEL_STATUS:  rd_val = {{(DATA_W-STATUS_W){1'b0}}, status_q};
      SEL_VERSION: rd_val = VERSION;
      SEL_TIMER:   rd_val = timer_q;
      SEL_SCRATCH: rd_val = scratch_q;
      default:     rd_val = '0;
    endcase
  end

  // Read data updates only on a read hit and holds otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      mi.mi_rd_data <= '0;
    end else if (rd_hit) begin
      mi.mi_rd_data <= rd_val;
    end
  end

endmodule

// File: tb/tb_ecfg_regs.sv
// Directed self-checking bench for ecfg_regs.
module tb_ecfg_regs;

  logic       clk;
  logic       reset;
  logic [7:0] status_in;
  logic       soft_reset;
  logic [31:0] ecfg_cfg;
  logic       timer_expired;

  int total;
  int bad;

  ecfg_if bus ();

  ecfg_regs dut (
    .clk           (clk),
    .reset         (reset),
    .mi            (bus),
    .status_in     (status_in),
    .soft_reset    (soft_reset),
    .ecfg_cfg      (ecfg_cfg),
    .timer_expired (timer_expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.mi_en   = 1'b0;
    bus.mi_we   = 4'h0;
    bus.mi_addr = 16'h0;
    bus.mi_din  = 32'h0;
  endtask

  task automatic drive_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] we);
    bus.mi_en   = 1'b1;
    bus.mi_we   = we;
    bus.mi_addr = a;
    bus.mi_din  = d;
  endtask

  task automatic drive_rd(input logic [15:0] a);
    bus.mi_en   = 1'b1;
    bus.mi_we   = 4'h0;
    bus.mi_addr = a;
    bus.mi_din  = 32'h0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] we);
    drive_wr(a, d, we);
    step();
    idle_bus();
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    drive_rd(a);
    step();
    idle_bus();
    d = bus.mi_rd_data;
  endtask

  logic [31:0] rd;

  initial begin
    total     = 0;
    bad       = 0;
    clk       = 1'b0;
    reset     = 1'b1;
    status_in = 8'h00;
    idle_bus();

    // Reset: accesses during reset are ignored
    step();
    drive_wr(16'h0004, 32'hFFFF_FFFF, 4'hF);
    status_in = 8'hFF;
    step();
    status_in = 8'h00;
    chk("rst_cfg", ecfg_cfg, 32'h0);
    chk("rst_rd", bus.mi_rd_data, 32'h0);
    chk("rst_srst", 32'(soft_reset), 32'h0);
    chk("rst_texp", 32'(timer_expired), 32'h0);

    // First access in the first cycle out of reset is honoured
    reset = 1'b0;
    drive_wr(16'h0004, 32'h1234_5678, 4'hF);
    step();
    idle_bus();
    chk("first_acc", ecfg_cfg, 32'h1234_5678);
    bus_read(16'h0008, rd);
    chk("status_rst", rd, 32'h0);

    // CFG byte-lane write
    bus_write(16'h0004, 32'h0, 4'hF);
    bus_write(16'h0004, 32'hA5A5_A5A5, 4'b0011);
    bus_read(16'h0004, rd);
    chk("cfg_lanes", rd, 32'h0000_A5A5);
    chk("cfg_port", ecfg_cfg, 32'h0000_A5A5);

    // SCRATCH lanes 1 and 3 only
    bus_write(16'h0014, 32'hDEAD_BEEF, 4'hF);
    bus_write(16'h0014, 32'h1122_3344, 4'b1010);
    bus_read(16'h0014, rd);
    chk("scratch_lanes", rd, 32'h11AD_33EF);

    // Out-of-window alias of CFG must not write
    bus_write(16'h0024, 32'hFFFF_FFFF, 4'hF);
    chk("alias_wr", ecfg_cfg, 32'h0000_A5A5);

    // VERSION read-only; non-hit read and writes hold mi_rd_data
    bus_read(16'h000C, rd);
    chk("version", rd, 32'h0000_0100);
    bus_write(16'h000C, 32'hFFFF_FFFF, 4'hF);
    chk("hold_on_wr", bus.mi_rd_data, 32'h0000_0100);
    bus_read(16'h0040, rd);
    chk("hold_nonhit", rd, 32'h0000_0100);
    bus_read(16'h000C, rd);
    chk("version_ro", rd, 32'h0000_0100);
    bus_write(16'h0018, 32'hFFFF_FFFF, 4'hF);
    bus_read(16'h0018, rd);
    chk("rsv_18", rd, 32'h0);
    bus_read(16'h000C, rd);
    bus_read(16'h001C, rd);
    chk("rsv_1c", rd, 32'h0);

    // STATUS sticky set, W1C, set wins over clear
    status_in = 8'h04;
    step();
    status_in = 8'h00;
    bus_read(16'h0008, rd);
    chk("status_set", rd, 32'h04);
    status_in = 8'h04;
    drive_wr(16'h0008, 32'h04, 4'b0001);
    step();
    idle_bus();
    status_in = 8'h00;
    bus_read(16'h0008, rd);
    chk("status_setwin", rd, 32'h04);
    bus_write(16'h0008, 32'h04, 4'b0001);
    bus_read(16'h0008, rd);
    chk("status_w1c", rd, 32'h00);
    status_in = 8'h81;
    step();
    status_in = 8'h00;
    bus_write(16'h0008, 32'hFFFF_FF01, 4'b0010);
    bus_read(16'h0008, rd);
    chk("status_we0", rd, 32'h81);
    bus_write(16'h0008, 32'hFFFF_FF01, 4'b0001);
    bus_read(16'h0008, rd);
    chk("status_part", rd, 32'h80);
    bus_write(16'h0008, 32'h80, 4'b0001);

    // RESET trigger qualifiers
    bus_write(16'h0000, 32'h1, 4'b0010);
    chk("srst_we0", 32'(soft_reset), 32'h0);
    bus_write(16'h0000, 32'h2, 4'b0001);
    chk("srst_din0", 32'(soft_reset), 32'h0);

    // Soft reset pulse: 16 cycles, retrigger at cycle 5 ignored
    bus_write(16'h0000, 32'h1, 4'b0001);
    for (int k = 1; k <= 18; k++) begin
      chk($sformatf("srst_k%0d", k), 32'(soft_reset), (k <= 16) ? 32'h1 : 32'h0);
      if (k == 9) chk("srst_rd", bus.mi_rd_data, 32'h1);
      if (k == 5)      drive_wr(16'h0000, 32'h1, 4'b0001);
      else if (k == 8) drive_rd(16'h0000);
      else             idle_bus();
      step();
    end
    idle_bus();
    bus_read(16'h0000, rd);
    chk("srst_rd_idle", rd, 32'h0);

`ifdef ECFG_TIMER_EN
    // Timer expiry 4 cycles after writing 3
    bus_write(16'h0010, 32'h3, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("texp_k%0d", k), 32'(timer_expired), (k == 4) ? 32'h1 : 32'h0);
      step();
    end
    bus_read(16'h0010, rd);
    chk("timer_zero", rd, 32'h0);
    bus_write(16'h0010, 32'h0, 4'hF);
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("texp0_k%0d", k), 32'(timer_expired), 32'h0);
      step();
    end
    bus_write(16'h0010, 32'h0000_0200, 4'hF);
    bus_read(16'h0010, rd);
    chk("timer_rd", rd, 32'h0000_0200);
    bus_write(16'h0010, 32'h0, 4'hF);
`else
    // Timer absent: 0x10 reads 0 and never expires
    bus_write(16'h0010, 32'h3, 4'hF);
    bus_read(16'h0010, rd);
    chk("timer_off_rd", rd, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("texp_off_k%0d", k), 32'(timer_expired), 32'h0);
      step();
    end
`endif

    // Reset in the middle of a soft-reset pulse and a countdown
    bus_write(16'h0004, 32'hCAFE_0001, 4'hF);
    bus_write(16'h0000, 32'h1, 4'b0001);
    bus_write(16'h0010, 32'd10, 4'hF);
    bus_read(16'h000C, rd);
    chk("pre_rst_rd", rd, 32'h0000_0100);
    chk("pre_rst_srst", 32'(soft_reset), 32'h1);
    reset = 1'b1;
    step();
    chk("mid_rst_srst", 32'(soft_reset), 32'h0);
    chk("mid_rst_rd", bus.mi_rd_data, 32'h0);
    chk("mid_rst_cfg", ecfg_cfg, 32'h0);
    reset = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      chk($sformatf("post_rst_k%0d", k), {30'h0, soft_reset, timer_expired}, 32'h0);
      step();
    end
    bus_read(16'h0010, rd);
    chk("post_rst_timer", rd, 32'h0);
    bus_read(16'h0014, rd);
    chk("post_rst_scratch", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
